// File: rtl/mem_pkg.sv
// Shared encodings and limits for the sized data memory.
// Purely declarative, so it adds no latency.
// No flow control lives here.
package mem_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
    localparam logic [1:0] MEM_SIZE_RSVD = 2'b11;

    localparam int READ_LATENCY_MAX = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    // Byte-lane enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] lanes;
        lanes = 4'b0000;
        case (size)
            MEM_SIZE_BYTE: lanes = 4'b0001 << offset;
            MEM_SIZE_HALF: lanes = offset[1] ? 4'b1100 : 4'b0011;
            MEM_SIZE_WORD: lanes = 4'b1111;
            default:       lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Lane select and sign/zero extension of a load result from a 32-bit word.
// Purely combinational, zero latency.
// No flow control; follows its inputs directly.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        ext_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend it according to size and signedness.
    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        data     = '0;
        case (size)
            MEM_SIZE_BYTE: data = ext_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            MEM_SIZE_HALF: data = ext_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            MEM_SIZE_WORD: data = word;
            default:       data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// Single-port byte/half/word data memory with in-order, fixed-latency responses.
// Latency: READ_LATENCY cycles from acceptance to resp_valid, one request per cycle.
// Backpressure: req_ready low only during reset and the post-reset clear sweep; responses never stall.
module data_memory_sized
    import mem_pkg::*;
#(
    parameter int DEPTH          = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           read_data
);

    localparam int IDX_W = $clog2(DEPTH);
    // Out-of-range latencies are clamped to the supported 1..READ_LATENCY_MAX window.
    localparam int LAT   = (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX :
                           (READ_LATENCY < 1) ? 1 : READ_LATENCY;

    logic [31:0]      mem_arr [DEPTH];
    mem_state_e       state_q, state_d;
    logic [IDX_W-1:0] clr_idx;

    logic             accept;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       offset;
    logic             out_of_range;
    logic             misaligned;
    logic             size_rsvd;
    logic             access_err;
    logic [3:0]       store_be;
    logic [31:0]      store_dat;
    logic [31:0]      rd_word;
    logic [31:0]      ld_data;
    logic [31:0]      resp_dat_in;

    logic [LAT-1:0]   pipe_vld;
    logic [LAT-1:0]   pipe_err;
    logic [31:0]      pipe_dat [LAT];

    assign word_idx     = address[IDX_W+1:2];
    assign offset       = address[1:0];
    assign out_of_range = |address[ADDR_WIDTH-1:IDX_W+2];
    assign size_rsvd    = (req_size == MEM_SIZE_RSVD);
    assign access_err   = out_of_range | misaligned | size_rsvd;

    // Ready is a pure function of state and reset so it never waits on req_valid.
    assign req_ready = (state_q == ST_READY) && !RST;
    assign accept    = req_valid && req_ready;

    // Alignment rules: halves need an even address, words need a 4-byte aligned address.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            MEM_SIZE_HALF: misaligned = offset[0];
            MEM_SIZE_WORD: misaligned = (offset != 2'b00);
            default:       misaligned = 1'b0;
        endcase
    end

    // State register; reset chooses between the clear sweep and immediate service.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave the clear sweep once the last word index has been written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_idx == IDX_W'(DEPTH - 1)) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_READY;
        endcase
    end

    // Sweep pointer walks 0..DEPTH-1 while clearing and restarts on every reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            clr_idx <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_idx <= clr_idx + IDX_W'(1);
        end
    end

    // Replicate store data into every lane so the byte enables alone pick the target.
    always_comb begin
        store_be  = store_lanes(req_size, offset);
        store_dat = write_data;
        case (req_size)
            MEM_SIZE_BYTE: store_dat = {4{write_data[7:0]}};
            MEM_SIZE_HALF: store_dat = {2{write_data[15:0]}};
            default:       store_dat = write_data;
        endcase
    end

    // Array writes: clear sweep, or a successful store committed on its acceptance edge.
    always_ff @(posedge CLK) begin
        if (state_q == ST_CLEAR && !RST) begin
            mem_arr[clr_idx] <= '0;
        end else if (accept && req_write && !access_err) begin
            for (int l = 0; l < 4; l++) begin
                if (store_be[l]) mem_arr[word_idx][8*l +: 8] <= store_dat[8*l +: 8];
            end
        end
    end

    // Combinational read so a load right after a store to the same word sees the new data.
    assign rd_word = mem_arr[word_idx];

    mem_load_align u_load_align (
        .word         (rd_word),
        .size         (req_size),
        .offset       (offset),
        .ext_unsigned (req_unsigned),
        .data         (ld_data)
    );

    assign resp_dat_in = (req_write || access_err) ? 32'd0 : ld_data;

    // Response shift pipe; reset drops everything in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 0; i < LAT; i++) pipe_dat[i] <= '0;
        end else begin
            pipe_vld[0] <= accept;
            pipe_err[0] <= accept && access_err;
            pipe_dat[0] <= accept ? resp_dat_in : 32'd0;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_err[i] <= pipe_err[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign resp_valid = pipe_vld[LAT-1];
    assign resp_err   = pipe_err[LAT-1];
    assign read_data  = pipe_dat[LAT-1];

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized with a response scoreboard.
// Checks data, error flag and exact latency of every response.
// Drives and samples on the falling clock edge.
module tb_data_memory_sized;
    import mem_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = 32;
    localparam int RL    = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] address = '0;
    logic [31:0]   write_data = '0;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   read_data;

    data_memory_sized #(
        .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .address(address),
        .write_data(write_data), .resp_valid(resp_valid), .resp_err(resp_err),
        .read_data(read_data)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [32:0] exp_q[$];
    int          acc_q[$];
    string       tag_q[$];

    logic [32:0] mon_e;
    int          mon_a;
    string       mon_t;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response must match the oldest outstanding request.
    always @(negedge CLK) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {31'b0, resp_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                mon_t = tag_q.pop_front();
                check({mon_t, "_err"},  {31'b0, resp_err}, {31'b0, mon_e[32]});
                check({mon_t, "_data"}, read_data, mon_e[31:0]);
                check({mon_t, "_lat"},  cyc - mon_a, RL - 1);
            end
        end
    end

    // Presents one request for one cycle; call at a falling edge.
    task automatic req(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_dat, input string tag);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            req_valid = 1'b0;
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check({tag, "_ready_timeout"}, {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        address      = a;
        write_data   = wd;
        exp_q.push_back({e_err, e_dat});
        acc_q.push_back(cyc + 1);
        tag_q.push_back(tag);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    // One-cycle reset, then measure how long the clear sweep holds req_ready low.
    task automatic reset_sweep(input string tag);
        int n;
        RST       = 1'b1;
        req_valid = 1'b0;
        exp_q.delete();
        acc_q.delete();
        tag_q.delete();
        #1;
        check({tag, "_rdy_in_rst"}, {31'b0, req_ready}, 32'd0);
        @(negedge CLK);
        check({tag, "_rst_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_rst_err"},   {31'b0, resp_err},   32'd0);
        check({tag, "_rst_data"},  read_data,           32'd0);
        RST = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_clear_cycles"}, n, DEPTH);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge CLK);

        // 1: clear sweep and zeroed contents
        reset_sweep("t1");
        req(0, MEM_SIZE_WORD, 0, 32'h00, 0, 0, 32'h0, "t1_lw0");
        req(0, MEM_SIZE_WORD, 0, 32'h40, 0, 0, 32'h0, "t1_lw40");
        req(0, MEM_SIZE_WORD, 0, 32'hFC, 0, 0, 32'h0, "t1_lwfc");
        idle(2);

        // 2: word store, byte/half lane extraction
        req(1, MEM_SIZE_WORD, 0, 32'h08, 32'h11223344, 0, 32'h0, "t2_sw8");
        req(0, MEM_SIZE_BYTE, 0, 32'h09, 0, 0, 32'h00000033, "t2_lb9");
        req(0, MEM_SIZE_BYTE, 0, 32'h0B, 0, 0, 32'h00000011, "t2_lbb");
        req(0, MEM_SIZE_HALF, 0, 32'h0A, 0, 0, 32'h00001122, "t2_lha");
        req(0, MEM_SIZE_WORD, 0, 32'h08, 0, 0, 32'h11223344, "t2_lw8");
        idle(2);

        // 3: byte/half stores into zeroed words, signed and unsigned loads
        req(1, MEM_SIZE_BYTE, 0, 32'h10, 32'hFFFFFF80, 0, 32'h0, "t3_sb10");
        req(0, MEM_SIZE_BYTE, 0, 32'h10, 0, 0, 32'hFFFFFF80, "t3_lb10");
        req(0, MEM_SIZE_BYTE, 1, 32'h10, 0, 0, 32'h00000080, "t3_lbu10");
        req(0, MEM_SIZE_WORD, 0, 32'h10, 0, 0, 32'h00000080, "t3_lw10");
        req(1, MEM_SIZE_HALF, 0, 32'h16, 32'h1234BEEF, 0, 32'h0, "t3_sh16");
        req(0, MEM_SIZE_HALF, 0, 32'h16, 0, 0, 32'hFFFFBEEF, "t3_lh16");
        req(0, MEM_SIZE_HALF, 1, 32'h16, 0, 0, 32'h0000BEEF, "t3_lhu16");
        req(0, MEM_SIZE_WORD, 0, 32'h14, 0, 0, 32'hBEEF0000, "t3_lw14");
        idle(2);

        // 4: misaligned, reserved and out-of-range accesses
        req(0, MEM_SIZE_WORD, 0, 32'h06,  0, 1, 32'h0, "t4_lw6");
        req(0, MEM_SIZE_HALF, 0, 32'h03,  0, 1, 32'h0, "t4_lh3");
        req(0, MEM_SIZE_RSVD, 0, 32'h08,  0, 1, 32'h0, "t4_rsvd");
        req(1, MEM_SIZE_WORD, 0, 32'h100, 32'hDEADBEEF, 1, 32'h0, "t4_sw100");
        req(1, MEM_SIZE_WORD, 0, 32'h02,  32'hFFFFFFFF, 1, 32'h0, "t4_sw2");
        req(1, MEM_SIZE_RSVD, 0, 32'h00,  32'hA5A5A5A5, 1, 32'h0, "t4_srsvd");
        req(0, MEM_SIZE_WORD, 0, 32'h00,  0, 0, 32'h0, "t4_lw0");
        idle(2);

        // 5: back-to-back loads, plus read-after-write on the next cycle
        req(1, MEM_SIZE_WORD, 0, 32'h20, 32'hCAFEF00D, 0, 32'h0, "t5_sw20");
        req(0, MEM_SIZE_WORD, 0, 32'h20, 0, 0, 32'hCAFEF00D, "t5_raw20");
        req(0, MEM_SIZE_WORD, 0, 32'h08, 0, 0, 32'h11223344, "t5_b0");
        req(0, MEM_SIZE_BYTE, 1, 32'h08, 0, 0, 32'h00000044, "t5_b1");
        req(0, MEM_SIZE_WORD, 0, 32'h10, 0, 0, 32'h00000080, "t5_b2");
        req(0, MEM_SIZE_HALF, 1, 32'h14, 0, 0, 32'h00000000, "t5_b3");
        req(0, MEM_SIZE_BYTE, 0, 32'h17, 0, 0, 32'hFFFFFFBE, "t5_b4");
        idle(RL + 2);

        // 6: reset with loads in flight drops them and reruns the sweep
        req(0, MEM_SIZE_WORD, 0, 32'h08, 0, 0, 32'h11223344, "t6_drop0");
        req(0, MEM_SIZE_WORD, 0, 32'h20, 0, 0, 32'hCAFEF00D, "t6_drop1");
        reset_sweep("t6");
        req(0, MEM_SIZE_WORD, 0, 32'h08, 0, 0, 32'h0, "t6_lw8");
        req(0, MEM_SIZE_WORD, 0, 32'h20, 0, 0, 32'h0, "t6_lw20");
        idle(1);

        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
